// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the autobaud controller
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    MEASURE,
    SETTLE,
    VERIFY,
    LOCKED,
    ERROR
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_RANGE   = 2'b10;
  localparam logic [1:0] ERR_VERIFY  = 2'b11;

  // 100 MHz / 115200 baud
  localparam int UART_DEFAULT_DIV = 868;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for the raw rx line with falling-edge pulse
module uart_rx_sync (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic rx_i,
  output logic rx_level_o,
  output logic fall_o
);

  // sh[0..1] synchronize, sh[2] is the edge-detect history; idle line is high
  logic [2:0] sh;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) sh <= 3'b111;
    else         sh <= {sh[1:0], rx_i};
  end

  assign rx_level_o = sh[1];
  assign fall_o     = sh[2] & ~sh[1];

endmodule

// File: rtl/uart_autobaud_ctrl.sv
// rtl/uart_autobaud_ctrl.sv - measures the host bit period from a sync char, programs and confirms uart_rx
module uart_autobaud_ctrl
  import uart_pkg::*;
#(
  parameter int             DIV_W       = 16,
  parameter int             DEFAULT_DIV = UART_DEFAULT_DIV,
  parameter int             MIN_DIV     = 16,
  parameter logic [7:0]     SYNC_BYTE   = 8'h55,
  parameter int             TIMEOUT_CYC = 2**24
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             rx_i,
  input  logic             start_i,
  input  logic             rx_done_tick_i,
  input  logic [7:0]       rx_data_i,
  output logic [DIV_W-1:0] baud_div_o,
  output logic             rx_rstn_o,
  output logic             busy_o,
  output logic             locked_o,
  output logic             err_o,
  output logic [1:0]       err_code_o
);

  localparam int CNT_W = DIV_W + 3;
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W:0]   DIV_LO  = (CNT_W+1)'(MIN_DIV);
  localparam logic [CNT_W:0]   DIV_HI  = (CNT_W+1)'((1 << DIV_W) - 1);
  localparam logic [TMR_W-1:0] TMR_END = TMR_W'(TIMEOUT_CYC - 1);

  logic rx_level, rx_fall;

  uart_rx_sync u_sync (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .rx_i       (rx_i),
    .rx_level_o (rx_level),
    .fall_o     (rx_fall)
  );

  state_t           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [2:0]       edges_q, edges_n;
  logic [TMR_W-1:0] timer_q, timer_n;
  logic [DIV_W:0]   high_q, high_n;
  logic [DIV_W-1:0] div_q, div_n;
  logic [DIV_W-1:0] good_q, good_n;
  logic [1:0]       code_q, code_n;
  logic             rx_rstn_q, busy_q, locked_q, err_q;

  logic [CNT_W:0]   span;
  logic [CNT_W:0]   div_calc;
  logic [DIV_W:0]   high_inc;
  logic             timeout;

  // span includes this cycle, so it equals the cycle distance between edge 1 and edge 5
  assign span     = {1'b0, cnt_q} + 1'b1;
  assign div_calc = (span + (CNT_W+1)'(4)) >> 3;
  assign high_inc = high_q + 1'b1;
  assign timeout  = (timer_q == TMR_END);

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    edges_n = edges_q;
    timer_n = timer_q;
    high_n  = high_q;
    div_n   = div_q;
    good_n  = good_q;
    code_n  = code_q;

    case (state_q)
      IDLE, LOCKED, ERROR: begin
        if (start_i) begin
          state_n = ARM;
          cnt_n   = '0;
          edges_n = '0;
          timer_n = '0;
          code_n  = ERR_NONE;
        end
      end
      ARM: begin
        cnt_n   = '0;
        edges_n = '0;
        timer_n = timer_q + 1'b1;
        if (rx_fall) begin
          state_n = MEASURE;
          edges_n = 3'd1;
        end else if (timeout) begin
          state_n = ERROR;
          code_n  = ERR_TIMEOUT;
        end
      end
      MEASURE: begin
        cnt_n = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_n = ERROR;
          code_n  = ERR_RANGE;
        end else if (rx_fall) begin
          edges_n = edges_q + 1'b1;
          if (edges_q == 3'd4) begin
            if (div_calc < DIV_LO || div_calc > DIV_HI) begin
              state_n = ERROR;
              code_n  = ERR_RANGE;
            end else begin
              state_n = SETTLE;
              div_n   = div_calc[DIV_W-1:0];
              high_n  = '0;
            end
          end
        end
      end
      SETTLE: begin
        // needs an unbroken high run of stop bit plus one idle bit
        if (!rx_level || rx_fall) begin
          high_n = '0;
        end else if (high_inc >= {div_q, 1'b0}) begin
          state_n = VERIFY;
          timer_n = '0;
        end else begin
          high_n = high_inc;
        end
      end
      VERIFY: begin
        timer_n = timer_q + 1'b1;
        if (rx_done_tick_i) begin
          if (rx_data_i == SYNC_BYTE) begin
            state_n = LOCKED;
            good_n  = div_q;
          end else begin
            state_n = ERROR;
            code_n  = ERR_VERIFY;
          end
        end else if (timeout) begin
          state_n = ERROR;
          code_n  = ERR_TIMEOUT;
        end
      end
      default: state_n = IDLE;
    endcase

    if (state_n == ERROR && state_q != ERROR) div_n = good_q;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      edges_q   <= '0;
      timer_q   <= '0;
      high_q    <= '0;
      div_q     <= DIV_W'(DEFAULT_DIV);
      good_q    <= DIV_W'(DEFAULT_DIV);
      code_q    <= ERR_NONE;
      rx_rstn_q <= 1'b1;
      busy_q    <= 1'b0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      edges_q   <= edges_n;
      timer_q   <= timer_n;
      high_q    <= high_n;
      div_q     <= div_n;
      good_q    <= good_n;
      code_q    <= code_n;
      rx_rstn_q <= !(state_n inside {ARM, MEASURE, SETTLE});
      busy_q    <= state_n inside {ARM, MEASURE, SETTLE, VERIFY};
      locked_q  <= (state_n == LOCKED);
      err_q     <= (state_n == ERROR);
    end
  end

  assign baud_div_o = div_q;
  assign rx_rstn_o  = rx_rstn_q;
  assign busy_o     = busy_q;
  assign locked_o   = locked_q;
  assign err_o      = err_q;
  assign err_code_o = code_q;

endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
// tb/tb_uart_autobaud_ctrl.sv - randomized bench for uart_autobaud_ctrl with a behavioural uart_rx stand-in
module tb_uart_autobaud_ctrl;

  localparam int TMO     = 12000;
  localparam int MIN_DIV = 16;
  localparam int DEF_DIV = 868;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rx = 1'b1;
  logic        start = 1'b0;
  logic        tick = 1'b0;
  logic [7:0]  rdata = 8'h00;
  logic [15:0] baud_div;
  logic        rx_rstn, busy, locked, err;
  logic [1:0]  err_code;

  int n_tests = 0;
  int n_fail  = 0;
  int last_good = DEF_DIV;

  always #5 clk = ~clk;

  uart_autobaud_ctrl #(
    .DIV_W       (16),
    .DEFAULT_DIV (DEF_DIV),
    .MIN_DIV     (MIN_DIV),
    .SYNC_BYTE   (8'h55),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .rx_i           (rx),
    .start_i        (start),
    .rx_done_tick_i (tick),
    .rx_data_i      (rdata),
    .baud_div_o     (baud_div),
    .rx_rstn_o      (rx_rstn),
    .busy_o         (busy),
    .locked_o       (locked),
    .err_o          (err),
    .err_code_o     (err_code)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Host frame: start bit, 8 data LSB first, stop bit; the stand-in receiver
  // reports the byte at the end of the stop bit if it is out of reset.
  task automatic send_char(input logic [7:0] b, input int p, input bit deliver);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = frame[i];
      idle(p);
    end
    if (deliver && rx_rstn) begin
      rdata = b;
      tick  = 1'b1;
      @(negedge clk);
      tick  = 1'b0;
    end
  endtask

  task automatic run_trial(input int p, input logic [7:0] b2, input bit poke);
    pulse_start();
    check("arm_busy", busy, 1);
    check("arm_rx_rstn", rx_rstn, 0);
    check("arm_err_clr", {err, err_code}, 0);
    check("arm_locked", locked, 0);
    idle(2 * p);
    send_char(8'h55, p, 1'b0);
    if (p < MIN_DIV) begin
      idle(4);
      check("range_err", err, 1);
      check("range_code", err_code, 2);
      check("range_div", baud_div, last_good);
      check("range_rx_rstn", rx_rstn, 1);
      return;
    end
    idle(p);
    if (poke) pulse_start();
    idle(2 * p);
    check("verify_busy", busy, 1);
    check("verify_rx_rstn", rx_rstn, 1);
    check("measured_div", baud_div, (8 * p + 4) >> 3);
    send_char(b2, p, 1'b1);
    idle(4);
    check("done_busy", busy, 0);
    if (b2 == 8'h55) begin
      last_good = p;
      check("lock", locked, 1);
      check("lock_err", err, 0);
      check("lock_div", baud_div, p);
    end else begin
      check("mismatch_err", err, 1);
      check("mismatch_code", err_code, 3);
      check("mismatch_div", baud_div, last_good);
      check("mismatch_locked", locked, 0);
    end
  endtask

  initial begin
    idle(3);
    check("rst_div", baud_div, DEF_DIV);
    check("rst_rx_rstn", rx_rstn, 1);
    check("rst_busy", busy, 0);
    check("rst_locked", locked, 0);
    check("rst_err", {err, err_code}, 0);
    rstn = 1'b1;
    idle(3);

    run_trial(868, 8'h55, 1'b0);
    run_trial(40, 8'hA3, 1'b0);

    for (int t = 0; t < 6; t++) begin
      int p;
      logic [7:0] b2;
      p  = $urandom_range(120, MIN_DIV);
      b2 = ($urandom_range(1, 0) == 0) ? 8'h55 : 8'($urandom_range(255, 0));
      run_trial(p, b2, t == 2);
      idle($urandom_range(20, 1));
    end

    run_trial(8, 8'h55, 1'b0);
    run_trial(MIN_DIV, 8'h55, 1'b0);

    pulse_start();
    idle(TMO + 10);
    check("tmo_err", err, 1);
    check("tmo_code", err_code, 1);
    check("tmo_busy", busy, 0);
    check("tmo_div", baud_div, last_good);

    // async reset in the middle of a measurement
    pulse_start();
    idle(100);
    rx = 1'b0; idle(50);
    rx = 1'b1; idle(50);
    rx = 1'b0; idle(20);
    rstn = 1'b0;
    #1;
    check("mrst_div", baud_div, DEF_DIV);
    check("mrst_rx_rstn", rx_rstn, 1);
    check("mrst_busy", busy, 0);
    check("mrst_flags", {locked, err, err_code}, 0);
    rx = 1'b1;
    last_good = DEF_DIV;
    idle(3);
    rstn = 1'b1;
    idle(3);
    run_trial(30, 8'h55, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
